// File: rtl/mac_dot_sequencer_pkg.sv
// Shared constants for the MAC dot-product sequencer: datapath widths,
// FSM state encoding and the bit positions inside cmd_signed.
package mac_dot_sequencer_pkg;

    localparam int unsigned OP_W  = 32;
    localparam int unsigned ACC_W = 64;
    localparam int unsigned SGN_W = 2;
    localparam int unsigned ST_W  = 3;

    // cmd_signed = {b_signed, a_signed}
    localparam int unsigned SGN_A = 0;
    localparam int unsigned SGN_B = 1;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_CLEAR = 3'd1;
    localparam logic [ST_W-1:0] ST_FETCH = 3'd2;
    localparam logic [ST_W-1:0] ST_ISSUE = 3'd3;
    localparam logic [ST_W-1:0] ST_WAIT  = 3'd4;
    localparam logic [ST_W-1:0] ST_DRAIN = 3'd5;
    localparam logic [ST_W-1:0] ST_DONE  = 3'd6;

    typedef enum logic [ST_W-1:0] {
        IDLE  = ST_IDLE,
        CLEAR = ST_CLEAR,
        FETCH = ST_FETCH,
        ISSUE = ST_ISSUE,
        WAIT  = ST_WAIT,
        DRAIN = ST_DRAIN,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/mac_dot_sequencer_if.sv
// Host-side bus of the dot-product sequencer: command, operand stream and
// result handshakes.
//   master : producer of commands/operands, consumer of results
//   slave  : the sequencer
interface mac_dot_sequencer_if #(
    parameter int unsigned LEN_W = 8
);
    logic                                        cmd_valid;
    logic                                        cmd_ready;
    logic [LEN_W-1:0]                            cmd_len;
    logic [mac_dot_sequencer_pkg::SGN_W-1:0]     cmd_signed;
    logic                                        op_valid;
    logic                                        op_ready;
    logic [mac_dot_sequencer_pkg::OP_W-1:0]      op_a;
    logic [mac_dot_sequencer_pkg::OP_W-1:0]      op_b;
    logic                                        res_valid;
    logic                                        res_ready;
    logic [mac_dot_sequencer_pkg::ACC_W-1:0]     res_data;
    logic [LEN_W-1:0]                            res_count;

    modport master (
        output cmd_valid, cmd_len, cmd_signed, op_valid, op_a, op_b, res_ready,
        input  cmd_ready, op_ready, res_valid, res_data, res_count
    );

    modport slave (
        input  cmd_valid, cmd_len, cmd_signed, op_valid, op_a, op_b, res_ready,
        output cmd_ready, op_ready, res_valid, res_data, res_count
    );
endinterface

// File: rtl/mac_dot_sequencer_watchdog.sv
// mac_watchdog: counts consecutive cycles with run=1 and flags expiry after
// TMO_CYC of them; err is sticky until reset. Only built with
// DOTSEQ_TIMEOUT_EN defined.
//   clk, rst   : clock, async active-low reset
//   run        : count enable; low restarts the count
//   expired_c  : combinational, high in the TMO_CYC-th running cycle
//   err        : registered sticky timeout flag
`ifdef DOTSEQ_TIMEOUT_EN
module mac_watchdog #(
    parameter int unsigned TMO_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expired_c,
    output logic err
);
    localparam int unsigned TW = $clog2(TMO_CYC + 1);

    logic [TW-1:0] cnt_q;

    assign expired_c = run && (cnt_q == TW'(TMO_CYC - 1));

    // Cycle counter and sticky flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err   <= 1'b0;
        end else begin
            if (!run) begin
                cnt_q <= '0;
            end else if (!expired_c) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (expired_c) begin
                err <= 1'b1;
            end
        end
    end
endmodule
`endif

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: drives one MAC unit through an N-element dot product.
// A command (length, signedness) is accepted, the MAC accumulator is cleared,
// then each operand pair is latched, started on the MAC and its mac_valid
// awaited. The final accumulator is returned on a valid/ready result port.
// Optional watchdog on the MAC response: macro DOTSEQ_TIMEOUT_EN.
// Ports:
//   clk, rst                 clock, async active-low reset
//   host (slave)             cmd / op / res handshakes
//   busy                     sequencer not idle
//   mac_rs1/rs2, *_signed    operands and signedness to the MAC
//   mac_start, mac_clear     single-cycle MAC controls
//   mac_result, mac_valid,
//   mac_busy                 MAC status inputs
//   err_timeout              sticky watchdog flag (0 without the macro)
module mac_dot_sequencer
    import mac_dot_sequencer_pkg::*;
#(
    parameter int unsigned LEN_W = 8
`ifdef DOTSEQ_TIMEOUT_EN
    , parameter int unsigned TMO_CYC = 64
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    mac_dot_sequencer_if.slave   host,
    output logic                 busy,
    output logic [OP_W-1:0]      mac_rs1,
    output logic [OP_W-1:0]      mac_rs2,
    output logic                 mac_rs1_signed,
    output logic                 mac_rs2_signed,
    output logic                 mac_start,
    output logic                 mac_clear,
    input  logic [ACC_W-1:0]     mac_result,
    input  logic                 mac_valid,
    input  logic                 mac_busy,
    output logic                 err_timeout
);
    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              cmd_fire_c;
    logic              op_fire_c;
    logic              pair_done_c;
    logic              tmo_hit_c;

    assign cmd_fire_c  = host.cmd_valid && host.cmd_ready;
    assign op_fire_c   = host.op_valid && host.op_ready;
    assign pair_done_c = (state_q == WAIT) && mac_valid;

`ifdef DOTSEQ_TIMEOUT_EN
    // Watchdog runs only while waiting for the MAC
    mac_watchdog #(
        .TMO_CYC (TMO_CYC)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .run       (state_q == WAIT),
        .expired_c (tmo_hit_c),
        .err       (err_timeout)
    );
`else
    assign tmo_hit_c   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (cmd_fire_c) state_d = CLEAR;
            CLEAR: state_d = (len_q == '0) ? DRAIN : FETCH;
            FETCH: if (op_fire_c) state_d = ISSUE;
            ISSUE: if (!mac_busy) state_d = WAIT;
            WAIT: begin
                if (mac_valid) begin
                    state_d = ((cnt_q + 1'b1) == len_q) ? DRAIN : FETCH;
                end else if (tmo_hit_c) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: state_d = DONE;
            DONE:  if (host.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register, registered outputs and datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            len_q          <= '0;
            cnt_q          <= '0;
            host.cmd_ready <= 1'b0;
            host.op_ready  <= 1'b0;
            host.res_valid <= 1'b0;
            host.res_data  <= '0;
            host.res_count <= '0;
            busy           <= 1'b0;
            mac_rs1        <= '0;
            mac_rs2        <= '0;
            mac_rs1_signed <= 1'b0;
            mac_rs2_signed <= 1'b0;
            mac_start      <= 1'b0;
            mac_clear      <= 1'b0;
        end else begin
            state_q        <= state_d;
            // Handshake/status outputs decoded from the next state so they
            // line up with the state they describe.
            host.cmd_ready <= (state_d == IDLE);
            host.op_ready  <= (state_d == FETCH);
            host.res_valid <= (state_d == DONE);
            busy           <= (state_d != IDLE);
            mac_clear      <= (state_d == CLEAR);
            // Start goes out once the MAC is free; ISSUE is left on the same edge
            mac_start      <= (state_q == ISSUE) && !mac_busy;

            if (cmd_fire_c) begin
                len_q          <= host.cmd_len;
                cnt_q          <= '0;
                mac_rs1_signed <= host.cmd_signed[SGN_A];
                mac_rs2_signed <= host.cmd_signed[SGN_B];
            end
            if (op_fire_c) begin
                mac_rs1 <= host.op_a;
                mac_rs2 <= host.op_b;
            end
            if (pair_done_c) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // Accumulator has settled one cycle after the last mac_valid
            if (state_q == DRAIN) begin
                host.res_data  <= mac_result;
                host.res_count <= cnt_q;
            end
        end
    end
endmodule
